// File: rtl/button_ctrl.sv
// Stopwatch control front end: per-button synchroniser, debouncer and edge
// detector feeding a priority-arbitrated mode FSM.

module btn_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sh;
  logic [CW-1:0]          cnt;
  logic                   diff;
  logic                   done;

  assign diff = sh[SYNC_STAGES-1] ^ level;
  assign done = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sh    <= '0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sh    <= {sh[SYNC_STAGES-2:0], raw};
      pulse <= 1'b0;
      if (!diff) begin
        cnt <= '0;
      end else if (done) begin
        // level accepts the new value; only a 0->1 change produces a pulse
        cnt   <= '0;
        level <= ~level;
        pulse <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module button_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LEGAL_ONLY      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] buttons,
  output logic [2:0] state,
  output logic       state_chg,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic       illegal_evt
);
  typedef enum logic [2:0] {
    ST_RESET = 3'b001,
    ST_COUNT = 3'b010,
    ST_PAUSE = 3'b011,
    ST_STOP  = 3'b100
  } state_t;

  state_t st;
  state_t req;
  logic   req_vld;
  logic   legal;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    btn_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .raw  (buttons[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end

  // Lowest-index pulse wins; the others are dropped.
  always_comb begin
    req_vld = |btn_pulse;
    req     = ST_RESET;
    if (btn_pulse[0])      req = ST_RESET;
    else if (btn_pulse[1]) req = ST_COUNT;
    else if (btn_pulse[2]) req = ST_PAUSE;
    else if (btn_pulse[3]) req = ST_STOP;
  end

  always_comb begin
    legal = 1'b0;
    case (st)
      ST_RESET: legal = (req == ST_COUNT);
      ST_COUNT: legal = (req == ST_PAUSE) || (req == ST_STOP) || (req == ST_RESET);
      ST_PAUSE: legal = (req == ST_COUNT) || (req == ST_STOP) || (req == ST_RESET);
      ST_STOP:  legal = (req == ST_RESET);
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= ST_RESET;
      state_chg   <= 1'b0;
      illegal_evt <= 1'b0;
    end else begin
      state_chg   <= 1'b0;
      illegal_evt <= 1'b0;
      if (!enable) begin
        if (st != ST_RESET) begin
          st        <= ST_RESET;
          state_chg <= 1'b1;
        end
      end else if (req_vld && (req != st)) begin
        if ((LEGAL_ONLY == 0) || legal) begin
          st        <= req;
          state_chg <= 1'b1;
        end else begin
          illegal_evt <= 1'b1;
        end
      end
    end
  end

  assign state = st;
endmodule

// File: doc/button_ctrl.md
Name: button_ctrl

Overview:
- Parametrised front end for the stopwatch control path.
- Takes four raw, asynchronous push-buttons (reset, count, pause, stop) plus the master enable switch, then synchronises, debounces and edge-detects each button.
- Drives the stopwatch mode register consumed by the counter/display logic.
- Compared with the previous control block, it adds configurable synchroniser depth and debounce length, an optional legal-transition mode, a proper synchronous reset, a state-change strobe and an illegal-request flag.

Parameters:
- SYNC_STAGES, 2: flip-flops per button synchroniser chain; minimum 2.
- DEBOUNCE_CYCLES, 1000: consecutive clk cycles a synchronised level must differ from the debounced level before it is accepted; minimum 1. Counter width is clog2(DEBOUNCE_CYCLES+1).
- LEGAL_ONLY, 1: 1 = only legal mode transitions are accepted; 0 = any button press forces its mode.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  master start switch, treated as already synchronous.
- buttons  in  4  raw asynchronous buttons, active-high: [0] reset, [1] count, [2] pause, [3] stop.
- state  out  3  mode: 3'b001 RESET, 3'b010 COUNT, 3'b011 PAUSE, 3'b100 STOP.
- state_chg  out  1  one-cycle pulse in the cycle state holds a new value.
- btn_level  out  4  debounced button levels.
- btn_pulse  out  4  one-cycle debounced rising-edge pulses.
- illegal_evt  out  1  one-cycle pulse when a winning press is rejected.

Behaviour:
- **Reset (reset=1 at an edge)**
  - Synchronisers, debounce counters and btn_level clear to 0; btn_pulse, state_chg and illegal_evt clear to 0; state becomes 3'b001.
  - Reset overrides all other inputs.
- **Synchroniser:** per bit, a shift chain of SYNC_STAGES registers. Its last stage is sync[i].
- **Debounce, per channel**
  - If sync[i]==btn_level[i], the counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, btn_level[i] toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES at sync[i] never changes btn_level.
- **Edge detect:** btn_pulse[i] is registered and is set on the same edge btn_level[i] goes 0->1. It is high for exactly one cycle. Falling edges produce no pulse.
- **Latency**
  - Take edge 1 as the first edge sampling the raw button high, with the button held.
  - btn_pulse is high after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - state and state_chg update at the following edge.
- **Arbitration:** when several btn_pulse bits are high in one cycle, the lowest index wins (reset > count > pause > stop). Losing pulses are discarded.
- **FSM, enable=1**
  - With LEGAL_ONLY=1, a winning request is accepted only if it is legal:
    - RESET: ->COUNT.
    - COUNT: ->PAUSE, STOP, RESET.
    - PAUSE: ->COUNT, STOP, RESET.
    - STOP: ->RESET only.
  - A request for the current state is a no-op. It gives no state_chg and no illegal_evt.
  - Any other rejected request pulses illegal_evt for one cycle at the edge where the state would have updated; state is unchanged.
  - With LEGAL_ONLY=0, every winning request sets state directly, and illegal_evt stays 0.
- **FSM, enable=0**
  - state is forced to RESET at the next edge, and btn_pulse requests are ignored.
  - Debouncers keep running, so btn_level and btn_pulse stay live.
  - state_chg pulses if the forced RESET changes state.
- **state_chg:** high for one cycle iff state differs from its previous value.
- **Held buttons**
  - A button held through reset release yields one btn_pulse after the normal latency, because btn_level restarts at 0.
  - A continuously held button never re-pulses.
- **Reset mid-debounce:** the partial count is lost and no pulse is produced from pre-reset activity.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LEGAL_ONLY=1 unless noted):
1. Reset, enable=1, hold buttons[1] from edge 1 -> btn_pulse=4'b0010 after edge 6 only; state=3'b010 and state_chg=1 after edge 7; then state_chg=0, with no further pulses while held.
2. 3-cycle high glitch on buttons[2] in COUNT -> btn_level, btn_pulse, state and illegal_evt unchanged.
3. Go to STOP via count then stop, then press pause -> illegal_evt=1 for one cycle, state stays 3'b100; press reset -> state=3'b001.
4. Press buttons[0] and buttons[3] together in the same cycle while in COUNT -> state=3'b001 and the stop request is discarded. Repeat with LEGAL_ONLY=0 from RESET pressing stop -> state=3'b100, illegal_evt never asserts.
5. In PAUSE, drop enable -> state=3'b001 with state_chg after the next edge; while enable=0, a count press shows a btn_pulse but state stays 3'b001.
6. Assert reset for 1 cycle with buttons[1] held and the counter at 2 -> all outputs 0 and state=3'b001; btn_pulse[1] fires 6 edges after release, and state goes to 3'b010.
